booth_pp_gen: RTL and testbench

Radix-4 Booth partial-product generator for the 32×32 multiplier datapath. It produces exactly the 16 × 64-bit rows consumed by the CSA reduction tree, in the tree's packed `pp_flat` layout. It accepts signed/unsigned operand pairs for MUL/MULH/MULHSU/MULHU through a 2-stage valid/ready pipeline. The row sum modulo 2^64 equals the full 64-bit product.

---
 rtl/mul_pkg.sv | 33 +++
 rtl/booth_row.sv | 34 +++
 rtl/booth_pp_gen.sv | 163 ++++++++++++++++
 tb/tb_booth_pp_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared constants and Booth digit type for the 32x32
//                multiplier datapath (partial-product generator and CSA tree).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Operand width, number of radix-4 rows and row width.
  localparam int XLEN = 32;
  localparam int PP_N = 16;
  localparam int PP_W = 64;

  // One radix-4 Booth digit: magnitude select (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Recode the overlapping triplet {b[2i+1], b[2i], b[2i-1]}.
  // 3'b111 is encoded as +0 so that no row ever carries a "negative zero".
  function automatic booth_digit_t booth_encode(input logic [2:0] trip);
    booth_digit_t dig;
    dig.neg = trip[2] & ~(trip[1] & trip[0]);
    dig.one = trip[1] ^ trip[0];
    dig.two = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
    return dig;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_row.sv
`default_nettype none
// ============================================================================
//  Module      : booth_row
//  Description : Combinational radix-4 Booth row: (d * A64) << 2*ROW_IDX,
//                full two's-complement, modulo 2^64.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_row
  import mul_pkg::*;
#(
  parameter int ROW_IDX = 0
) (
  input  logic [PP_W-1:0] a64,
  input  booth_digit_t    digit,
  output logic [PP_W-1:0] row
);

  logic [PP_W-1:0] mag;
  logic [PP_W-1:0] signed_mag;

  // Pick |d|*A, apply the digit sign with a complete negation, then weight it.
  always_comb begin
    mag = '0;
    if (digit.one) begin
      mag = a64;
    end else if (digit.two) begin
      mag = {a64[PP_W-2:0], 1'b0};
    end
    signed_mag = digit.neg ? ((~mag) + PP_W'(1)) : mag;
    row        = signed_mag << (2 * ROW_IDX);
  end

endmodule
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_gen
//  Description : Radix-4 Booth partial-product generator, 2-stage valid/ready
//                pipeline. S1 holds the extended multiplicand and recoded
//                digits, S2 holds the 16 finished rows in pp_flat layout.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PP_N*PP_W-1:0] pp_flat,
  output logic [TAG_W-1:0]     out_tag
);

  // The row count and correction weight are fixed to a 32-bit operand.
  if (XLEN != mul_pkg::XLEN) begin : g_xlen_check
    $error("booth_pp_gen: only XLEN = 32 is supported");
  end

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic                              s1_valid_q, s1_valid_d;
  logic [PP_W-1:0]                   s1_a64_q,   s1_a64_d;
  booth_digit_t [PP_N-1:0]           s1_dig_q,   s1_dig_d;
  logic                              s1_corr_q,  s1_corr_d;
  logic [TAG_W-1:0]                  s1_tag_q,   s1_tag_d;

  logic                              s2_valid_q, s2_valid_d;
  logic [PP_N-1:0][PP_W-1:0]         s2_rows_q,  s2_rows_d;
  logic [TAG_W-1:0]                  s2_tag_q,   s2_tag_d;

  // Handshake helpers
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic s2_load;

  // Stage-1 combinational products
  logic [PP_W-1:0]  a64_ext;
  logic [XLEN:0]    b_ext;

  // Stage-2 combinational rows
  logic [PP_W-1:0]           row_raw [PP_N];
  logic [PP_N-1:0][PP_W-1:0] rows_w;

  // Advance conditions: a stage moves when it is empty or its consumer moves.
  // in_ready never looks at in_valid or the operands.
  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_ready = s1_adv & ~flush;
    in_fire  = in_valid & in_ready;
    s2_load  = s2_adv & s1_valid_q;
  end

  // Operand extension and Booth recoding feeding S1.
  always_comb begin
    a64_ext = {{(PP_W-XLEN){a_signed & op_a[XLEN-1]}}, op_a};
    b_ext   = {op_b, 1'b0};
    s1_dig_d = s1_dig_q;
    if (in_fire) begin
      for (int i = 0; i < PP_N; i++) begin
        s1_dig_d[i] = booth_encode(b_ext[2*i +: 3]);
      end
    end
  end

  // S1 next state: capture on accept, flush kills the valid bit only.
  always_comb begin
    s1_a64_d  = in_fire ? a64_ext : s1_a64_q;
    s1_corr_d = in_fire ? (~b_signed & op_b[XLEN-1]) : s1_corr_q;
    s1_tag_d  = in_fire ? in_tag : s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Sixteen row generators working from the S1 registers.
  for (genvar gi = 0; gi < PP_N; gi++) begin : g_row
    booth_row #(
      .ROW_IDX (gi)
    ) u_booth_row (
      .a64   (s1_a64_q),
      .digit (s1_dig_q[gi]),
      .row   (row_raw[gi])
    );
  end

  // Assemble rows; row 15 also absorbs the unsigned-multiplier correction
  // (+A64 << 32) because the top digit treated b[31] as a negative weight.
  always_comb begin
    for (int i = 0; i < PP_N; i++) begin
      rows_w[i] = row_raw[i];
    end
    if (s1_corr_q) begin
      rows_w[PP_N-1] = row_raw[PP_N-1] + {s1_a64_q[PP_W-XLEN-1:0], {XLEN{1'b0}}};
    end
  end

  // S2 next state: load only when S1 hands over a real entry, otherwise hold
  // so the outputs stay stable under backpressure.
  always_comb begin
    s2_rows_d = s2_load ? rows_w : s2_rows_q;
    s2_tag_d  = s2_load ? s1_tag_q : s2_tag_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // State registers; reset clears valids and all data, and dominates flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a64_q   <= '0;
      s1_dig_q   <= '0;
      s1_corr_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_rows_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a64_q   <= s1_a64_d;
      s1_dig_q   <= s1_dig_d;
      s1_corr_q  <= s1_corr_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_rows_q  <= s2_rows_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign pp_flat   = s2_rows_q;
  assign out_tag   = s2_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_booth_pp_gen
//  Description : Self-checking bench for booth_pp_gen: directed products,
//                random back-to-back sweep, backpressure, flush and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_pp_gen;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      op_a = '0;
  logic [31:0]      op_b = '0;
  logic             a_signed = 1'b0;
  logic             b_signed = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1023:0]    pp_flat;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  booth_pp_gen #(
    .XLEN  (32),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_flat   (pp_flat),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             as;
    logic             bs;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  logic smp_in_ready;
  logic smp_out_valid;
  logic [31:0] corner [5];

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ext64(input logic [31:0] v, input logic s);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  // Reference product: plain 64-bit multiply of the extended operands.
  function automatic logic [63:0] ref_prod(input ent_t e);
    return ext64(e.a, e.as) * ext64(e.b, e.bs);
  endfunction

  // Reference row from the digit rule d_i = -2 b[2i+1] + b[2i] + b[2i-1].
  function automatic logic [63:0] ref_row(input ent_t e, input int i);
    longint      d;
    longint      av;
    logic [63:0] r;
    d = -2 * longint'(e.b[2*i+1]) + longint'(e.b[2*i]);
    if (i > 0) d = d + longint'(e.b[2*i-1]);
    av = longint'(ext64(e.a, e.as));
    r  = 64'(d * av) << (2 * i);
    if (i == 15 && !e.bs && e.b[31]) r = r + (ext64(e.a, e.as) << 32);
    return r;
  endfunction

  function automatic logic [63:0] row_sum();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + pp_flat[i*64 +: 64];
    return s;
  endfunction

  task automatic check_entry(input ent_t e);
    for (int i = 0; i < 16; i++) begin
      check("row", pp_flat[i*64 +: 64], ref_row(e, i));
    end
    check("tag", 64'(out_tag), 64'(e.tag));
    check("sum", row_sum(), ref_prod(e));
  endtask

  task automatic drive_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic bs, input logic [TAG_W-1:0] t);
    in_valid = v;
    op_a     = a;
    op_b     = b;
    a_signed = as;
    b_signed = bs;
    in_tag   = t;
  endtask

  // One clock: sample and score at the falling edge, return 1ns after rise.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    smp_in_ready  = in_ready;
    smp_out_valid = out_valid;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check_entry(exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e.a = op_a; e.b = op_b; e.as = a_signed; e.bs = b_signed; e.tag = in_tag;
        exp_q.push_back(e);
      end
      if (flush) exp_q.delete();
    end else begin
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      tick();
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Send one operand pair into an empty pipe and check latency and row sum.
  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic as,
                          input logic bs, input logic [63:0] exp_sum);
    out_ready = 1'b0;
    drive_in(1'b1, a, b, as, bs, 5'd7);
    tick();
    check("dir_accept", 64'(smp_in_ready), 64'd1);
    in_valid = 1'b0;
    check("dir_lat1", 64'(out_valid), 64'd0);
    tick();
    check("dir_lat2", 64'(out_valid), 64'd1);
    check("dir_sum", row_sum(), exp_sum);
    drain(10);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] ra, rb;
    int k;
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    for (int i = 0; i < 16; i++) check("rst_row", pp_flat[i*64 +: 64], 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // ---------------- directed products ----------------
    out_ready = 1'b0;
    drive_in(1'b1, 32'd3, 32'd5, 1'b1, 1'b1, 5'd3);
    tick();
    in_valid = 1'b0;
    tick();
    check("b_row0", pp_flat[63:0], 64'd3);
    check("b_row1", pp_flat[127:64], 64'd12);
    check("b_rows_hi_zero", 64'(|pp_flat[1023:128]), 64'd0);
    drain(10);
    directed(32'd3, 32'd5, 1'b1, 1'b1, 64'd15);
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'd1);
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
    directed(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);

    // ---------------- random back-to-back sweep ----------------
    out_ready = 1'b1;
    k = 0;
    for (int p = 0; p < 10000; p++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = corner[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) rb = corner[$urandom_range(0, 4)];
      for (int c = 0; c < 4; c++) begin
        drive_in(1'b1, ra, rb, c[1], c[0], TAG_W'($urandom));
        tick();
        check("stream_in_ready", 64'(smp_in_ready), 64'd1);
        if (k >= 2) check("stream_out_valid", 64'(smp_out_valid), 64'd1);
        k++;
      end
    end
    drain(10);

    // ---------------- backpressure ----------------
    n0 = n_out;
    out_ready = 1'b0;
    drive_in(1'b1, $urandom, $urandom, 1'b1, 1'b0, 5'd1);
    tick();
    check("bp_acc1", 64'(smp_in_ready), 64'd1);
    drive_in(1'b1, $urandom, $urandom, 1'b0, 1'b1, 5'd2);
    tick();
    check("bp_acc2", 64'(smp_in_ready), 64'd1);
    drive_in(1'b1, $urandom, $urandom, 1'b0, 1'b0, 5'd3);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp_stall", 64'(smp_in_ready), 64'd0);
    end
    check("bp_inflight", 64'(exp_q.size()), 64'd2);
    out_ready = 1'b1;
    tick();
    check("bp_accept_drain", 64'(smp_in_ready), 64'd1);
    drain(10);
    check("bp_count", 64'(n_out - n0), 64'd3);

    // ---------------- flush ----------------
    out_ready = 1'b0;
    drive_in(1'b1, $urandom, $urandom, 1'b1, 1'b1, 5'd10);
    tick();
    drive_in(1'b1, $urandom, $urandom, 1'b1, 1'b1, 5'd11);
    tick();
    drive_in(1'b1, $urandom, $urandom, 1'b1, 1'b1, 5'd12);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready", 64'(smp_in_ready), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    n0 = n_out;
    drive_in(1'b1, $urandom, $urandom, 1'b0, 1'b1, 5'd13);
    tick();
    drain(10);
    check("fl_count", 64'(n_out - n0), 64'd1);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    drive_in(1'b1, $urandom, $urandom, 1'b1, 1'b1, 5'd20);
    tick();
    drive_in(1'b1, $urandom, $urandom, 1'b0, 1'b0, 5'd21);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_tag", 64'(out_tag), 64'd0);
    for (int i = 0; i < 16; i++) check("mr_row", pp_flat[i*64 +: 64], 64'd0);
    rst_n = 1'b1;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'd1);

    // ---------------- random valid/ready with occasional flush ----------------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_in($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
               TAG_W'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0;
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
